clock_core_param: RTL and testbench

Parametrised time-of-day engine, successor to the fixed 24/12-hour clock counter.
- Keeps one canonical 24-hour time base (hour/minute/second) advanced by an external 1 Hz enable.
- Derives the 12-hour view and the AM/PM flag from that base, so there is no separate 12-hour count path.
- Adds a validated load handshake, per-field up/down adjust, a day-rollover pulse and a parametrised day counter.
- Sits between the tick prescaler / key-decode logic and the display formatter.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/mod_wrap_cnt.sv | 44 ++++
 rtl/clock_core_param.sv | 142 ++++++++++++++
 tb/tb_clock_core_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day engine: field limits, adjust-field
// select codes and the control FSM state encoding.
package clock_pkg;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // adj_field encoding
    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // control FSM states
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ADJ  = 2'd2;

    // 12-hour view of a canonical 0..23 hour: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [4:0] to_12h(input logic [4:0] h);
        if (h == 5'd0)       return 5'd12;
        else if (h > 5'd12)  return h - 5'd12;
        else                 return h;
    endfunction

endpackage

// File: rtl/mod_wrap_cnt.sv
// Wrapping up/down counter for one time field (0..MAX).
// load has priority over stepping; inc and dec together cancel.
// carry flags an increment that wraps MAX -> 0 this cycle.
module mod_wrap_cnt #(
    parameter int W       = 6,
    parameter int MAX     = 59,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] RST_V = W'(RST_VAL);

    logic [W-1:0] value_q, value_d;

    // Next value: load, else single step with wrap in either direction.
    always_comb begin
        value_d = value_q;
        if (load)
            value_d = load_val;
        else if (inc && !dec)
            value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
        else if (dec && !inc)
            value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
    end

    // Field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= RST_V;
        else        value_q <= value_d;
    end

    assign value = value_q;
    assign carry = inc & ~dec & ~load & (value_q == MAX_V);

endmodule

// File: rtl/clock_core_param.sv
// Parametrised 24-hour time-of-day engine with load handshake, per-field
// adjust, day rollover pulse and day counter. The 12-hour view and pm flag
// are derived combinationally from the single 24-hour base.
// Optional alarm compare is enabled by defining CLOCK_ALARM_EN.
//
// Load handshake: a load transfers when load_valid & load_ready are both
// high on a clock edge; load_ready is high outside ADJ. An accepted load
// with an out-of-range field leaves the time untouched and pulses load_err.
module clock_core_param
    import clock_pkg::*;
#(
    parameter int RST_HOUR  = 0,
    parameter int RST_MIN   = 0,
    parameter int RST_SEC   = 0,
    parameter int DAY_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic                 run,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [4:0]           load_hour,
    input  logic [5:0]           load_min,
    input  logic [5:0]           load_sec,
    output logic                 load_err,
    input  logic [1:0]           adj_field,
    input  logic                 adj_up,
    input  logic                 adj_down,
    input  logic                 fmt_12h,
    output logic [4:0]           hour,
    output logic [5:0]           minute,
    output logic [5:0]           second,
    output logic [4:0]           disp_hour,
    output logic                 pm,
    output logic                 day_pulse,
    output logic [DAY_CNT_W-1:0] day_count,
`ifdef CLOCK_ALARM_EN
    input  logic                 alarm_arm,
    input  logic [4:0]           alarm_hour,
    input  logic [5:0]           alarm_min,
    output logic                 alarm_hit,
`endif
    output logic [1:0]           dbg_state
);

    logic [1:0]           state_q, state_d;
    logic [DAY_CNT_W-1:0] day_count_q;
    logic                 day_pulse_q, load_err_q;
    logic                 in_run, in_adj;
    logic                 load_acc, load_ok, load_apply;
    logic                 step_up, step_dn, tick, rollover;
    logic                 sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
    logic                 sec_carry, min_carry, hour_carry;

    assign in_run     = (state_q == ST_RUN);
    assign in_adj     = (state_q == ST_ADJ);
    assign load_ready = ~in_adj;
    assign load_acc   = load_valid & load_ready;
    assign load_ok    = (load_hour <= 5'(HOUR_MAX)) && (load_min <= 6'(MIN_MAX))
                        && (load_sec <= 6'(SEC_MAX));
    assign load_apply = load_acc & load_ok;

    // Adjust only in ADJ; a simultaneous up/down is a no-op.
    assign step_up  = in_adj & adj_up & ~adj_down;
    assign step_dn  = in_adj & adj_down & ~adj_up;
    // A tick is lost (not queued) when a load is accepted in the same cycle.
    assign tick     = in_run & tick_en & ~load_acc;

    // Carries only ripple on ticks; adjust never carries into neighbours.
    assign sec_inc  = tick | (step_up & (adj_field == FIELD_SEC));
    assign sec_dec  = step_dn & (adj_field == FIELD_SEC);
    assign min_inc  = (tick & sec_carry) | (step_up & (adj_field == FIELD_MIN));
    assign min_dec  = step_dn & (adj_field == FIELD_MIN);
    assign hour_inc = (tick & sec_carry & min_carry) | (step_up & (adj_field == FIELD_HOUR));
    assign hour_dec = step_dn & (adj_field == FIELD_HOUR);
    assign rollover = tick & sec_carry & min_carry & hour_carry;

    mod_wrap_cnt #(.W(6), .MAX(SEC_MAX), .RST_VAL(RST_SEC)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(sec_inc), .dec(sec_dec),
        .load(load_apply), .load_val(load_sec), .value(second), .carry(sec_carry)
    );

    mod_wrap_cnt #(.W(6), .MAX(MIN_MAX), .RST_VAL(RST_MIN)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(min_inc), .dec(min_dec),
        .load(load_apply), .load_val(load_min), .value(minute), .carry(min_carry)
    );

    mod_wrap_cnt #(.W(5), .MAX(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
        .clk(clk), .rst_n(rst_n), .inc(hour_inc), .dec(hour_dec),
        .load(load_apply), .load_val(load_hour), .value(hour), .carry(hour_carry)
    );

    // Mode select: any non-zero field forces ADJ, otherwise run picks RUN/HOLD.
    always_comb begin
        state_d = ST_HOLD;
        if (adj_field != FIELD_NONE) state_d = ST_ADJ;
        else if (run)                state_d = ST_RUN;
    end

    // State, day counter and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            day_count_q <= '0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            day_pulse_q <= rollover;
            load_err_q  <= load_acc & ~load_ok;
            if (rollover) day_count_q <= day_count_q + 1'b1;
        end
    end

`ifdef CLOCK_ALARM_EN
    logic       alarm_hit_q;
    logic [5:0] min_next;
    logic [4:0] hour_next;

    // Time a tick would produce when seconds wrap to 00.
    assign min_next  = min_carry ? 6'd0 : minute + 6'd1;
    assign hour_next = min_carry ? (hour_carry ? 5'd0 : hour + 5'd1) : hour;

    // Alarm fires only on tick-produced hh:mm:00, aligned with the new time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alarm_hit_q <= 1'b0;
        else        alarm_hit_q <= alarm_arm & tick & sec_carry
                                   & (min_next == alarm_min) & (hour_next == alarm_hour);
    end

    assign alarm_hit = alarm_hit_q;
`endif

    assign disp_hour = fmt_12h ? to_12h(hour) : hour;
    assign pm        = (hour >= 5'd12);
    assign day_pulse = day_pulse_q;
    assign day_count = day_count_q;
    assign load_err  = load_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_clock_core_param.sv
module tb_clock_core_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick_en = 1'b0, run = 1'b1, load_valid = 1'b0;
  logic [4:0]  load_hour = '0;
  logic [5:0]  load_min = '0, load_sec = '0;
  logic [1:0]  adj_field = '0;
  logic        adj_up = 1'b0, adj_down = 1'b0, fmt_12h = 1'b0;
  logic        load_ready, load_err, pm, day_pulse;
  logic [4:0]  hour, disp_hour;
  logic [5:0]  minute, second;
  logic [15:0] day_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model: seconds since midnight, mode 0=RUN 1=HOLD 2=ADJ
  int m_t, m_mode, m_day, m_pulse, m_err;

  clock_core_param #(
    .RST_HOUR(23), .RST_MIN(59), .RST_SEC(58), .DAY_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .run(run),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .load_err(load_err), .adj_field(adj_field), .adj_up(adj_up),
    .adj_down(adj_down), .fmt_12h(fmt_12h), .hour(hour), .minute(minute),
    .second(second), .disp_hour(disp_hour), .pm(pm), .day_pulse(day_pulse),
    .day_count(day_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int exp_disp(int h, bit f);
    if (!f) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  task automatic model_reset();
    m_t = 23 * 3600 + 59 * 60 + 58;
    m_mode = 0; m_day = 0; m_pulse = 0; m_err = 0;
  endtask

  task automatic model_step();
    int h, m, s, d;
    m_pulse = 0; m_err = 0;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    if (load_valid && m_mode != 2) begin
      if (load_hour <= 23 && load_min <= 59 && load_sec <= 59)
        m_t = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
      else
        m_err = 1;
    end else if (m_mode == 2 && adj_field != 0 && adj_up != adj_down) begin
      d = adj_up ? 1 : -1;
      case (adj_field)
        2'd1: h = (h + d + 24) % 24;
        2'd2: m = (m + d + 60) % 60;
        default: s = (s + d + 60) % 60;
      endcase
      m_t = h * 3600 + m * 60 + s;
    end else if (m_mode == 0 && tick_en) begin
      m_t = (m_t + 1) % 86400;
      if (m_t == 0) begin
        m_pulse = 1;
        m_day = (m_day + 1) % 65536;
      end
    end
    m_mode = (adj_field != 0) ? 2 : (run ? 0 : 1);
  endtask

  // one clock: model advances with the same inputs the DUT samples
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #11;
    checks++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd58) begin
      failures++; $display("FAIL reset_time: got %0d:%0d:%0d expected 23:59:58", hour, minute, second);
    end
    checks++;
    if (day_count !== 16'd0 || day_pulse !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got day=%0d pulse=%0b err=%0b expected 0/0/0", day_count, day_pulse, load_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rollover();
    run = 1'b1; tick_en = 1'b1;
    cycle();
    checks++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd59 || day_pulse !== 1'b0) begin
      failures++; $display("FAIL tick_to_59: got %0d:%0d:%0d pulse=%0b expected 23:59:59 pulse=0", hour, minute, second, day_pulse);
    end
    cycle();
    tick_en = 1'b0;
    checks++;
    if (hour !== 5'd0 || minute !== 6'd0 || second !== 6'd0 || day_pulse !== 1'b1 || day_count !== 16'd1) begin
      failures++; $display("FAIL rollover: got %0d:%0d:%0d pulse=%0b day=%0d expected 0:0:0 pulse=1 day=1", hour, minute, second, day_pulse, day_count);
    end
    cycle();
    checks++;
    if (day_pulse !== 1'b0 || day_count !== 16'd1 || second !== 6'd0) begin
      failures++; $display("FAIL pulse_width: got pulse=%0b day=%0d sec=%0d expected 0/1/0", day_pulse, day_count, second);
    end
  endtask

  task automatic test_load_hold();
    run = 1'b0;
    cycle();
    load_valid = 1'b1; load_hour = 5'd13; load_min = 6'd5; load_sec = 6'd0;
    tick_en = 1'b1; fmt_12h = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin
      failures++; $display("FAIL ready_hold: got %0b expected 1", load_ready);
    end
    cycle();
    load_valid = 1'b0; tick_en = 1'b0;
    checks++;
    if (hour !== 5'd13 || minute !== 6'd5 || second !== 6'd0 || load_err !== 1'b0) begin
      failures++; $display("FAIL load_hold: got %0d:%0d:%0d err=%0b expected 13:5:0 err=0", hour, minute, second, load_err);
    end
    checks++;
    if (disp_hour !== 5'd1 || pm !== 1'b1) begin
      failures++; $display("FAIL load_12h: got disp=%0d pm=%0b expected 1/1", disp_hour, pm);
    end
  endtask

  task automatic test_load_err();
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1;
      load_hour = (k == 0) ? 5'd24 : 5'd3;
      load_min  = (k == 0) ? 6'd10 : 6'd60;
      load_sec  = 6'd0;
      cycle();
      load_valid = 1'b0;
      checks++;
      if (load_err !== 1'b1 || hour !== 5'(m_t / 3600) || minute !== 6'((m_t / 60) % 60)) begin
        failures++; $display("FAIL load_err%0d: got err=%0b %0d:%0d expected err=1 %0d:%0d", k, load_err, hour, minute, m_t / 3600, (m_t / 60) % 60);
      end
      cycle();
      checks++;
      if (load_err !== 1'b0) begin
        failures++; $display("FAIL load_err_width%0d: got %0b expected 0", k, load_err);
      end
    end
  endtask

  task automatic test_adjust();
    load_valid = 1'b1; load_hour = 5'd13; load_min = 6'd59; load_sec = 6'd10;
    cycle();
    load_valid = 1'b0; run = 1'b1; adj_field = 2'd2;
    cycle();
    checks++;
    if (load_ready !== 1'b0) begin
      failures++; $display("FAIL ready_adj: got %0b expected 0", load_ready);
    end
    adj_up = 1'b1; tick_en = 1'b1;
    cycle();
    adj_up = 1'b0;
    checks++;
    if (minute !== 6'd0 || hour !== 5'd13 || second !== 6'd10) begin
      failures++; $display("FAIL adj_wrap: got %0d:%0d:%0d expected 13:0:10", hour, minute, second);
    end
    repeat (3) cycle();
    checks++;
    if (second !== 6'd10) begin
      failures++; $display("FAIL adj_tick_ignored: got sec=%0d expected 10", second);
    end
    adj_up = 1'b1; adj_down = 1'b1;
    cycle();
    checks++;
    if (minute !== 6'd0) begin
      failures++; $display("FAIL adj_both: got min=%0d expected 0", minute);
    end
    adj_up = 1'b0;
    cycle();
    adj_down = 1'b0;
    checks++;
    if (minute !== 6'd59 || hour !== 5'd13) begin
      failures++; $display("FAIL adj_down_wrap: got %0d:%0d expected 13:59", hour, minute);
    end
    adj_field = 2'd0; tick_en = 1'b0;
    cycle();
  endtask

  task automatic test_12h();
    fmt_12h = 1'b1;
    load_valid = 1'b1; load_hour = 5'd0; load_min = 6'd0; load_sec = 6'd0;
    cycle();
    checks++;
    if (disp_hour !== 5'd12 || pm !== 1'b0) begin
      failures++; $display("FAIL midnight_12h: got disp=%0d pm=%0b expected 12/0", disp_hour, pm);
    end
    load_hour = 5'd12; load_min = 6'd30;
    cycle();
    load_valid = 1'b0;
    checks++;
    if (disp_hour !== 5'd12 || pm !== 1'b1) begin
      failures++; $display("FAIL noon_12h: got disp=%0d pm=%0b expected 12/1", disp_hour, pm);
    end
    fmt_12h = 1'b0;
    #1;
    checks++;
    if (disp_hour !== 5'd12 || hour !== 5'd12 || pm !== 1'b1) begin
      failures++; $display("FAIL fmt_toggle: got disp=%0d hour=%0d pm=%0b expected 12/12/1", disp_hour, hour, pm);
    end
    load_valid = 1'b1; load_hour = 5'd23;
    cycle();
    load_valid = 1'b0; fmt_12h = 1'b1;
    #1;
    checks++;
    if (disp_hour !== 5'd11 || hour !== 5'd23) begin
      failures++; $display("FAIL late_12h: got disp=%0d hour=%0d expected 11/23", disp_hour, hour);
    end
  endtask

  task automatic test_random();
    load_valid = 1'b1; load_hour = 5'd23; load_min = 6'd59; load_sec = 6'd30;
    cycle();
    for (int n = 0; n < 400; n++) begin
      tick_en    = ($urandom_range(0, 3) != 0);
      run        = ($urandom_range(0, 4) != 0);
      load_valid = ($urandom_range(0, 11) == 0);
      load_hour  = 5'($urandom_range(0, 25));
      load_min   = 6'($urandom_range(0, 61));
      load_sec   = 6'($urandom_range(50, 61));
      adj_field  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      adj_up     = 1'($urandom_range(0, 1));
      adj_down   = 1'($urandom_range(0, 1));
      fmt_12h    = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (hour !== 5'(m_t / 3600) || minute !== 6'((m_t / 60) % 60) || second !== 6'(m_t % 60)) begin
        failures++; $display("FAIL rnd_time[%0d]: got %0d:%0d:%0d expected %0d:%0d:%0d", n, hour, minute, second, m_t / 3600, (m_t / 60) % 60, m_t % 60);
      end
      checks++;
      if (disp_hour !== 5'(exp_disp(m_t / 3600, fmt_12h)) || pm !== ((m_t / 3600) >= 12)) begin
        failures++; $display("FAIL rnd_disp[%0d]: got disp=%0d pm=%0b expected disp=%0d", n, disp_hour, pm, exp_disp(m_t / 3600, fmt_12h));
      end
      checks++;
      if (day_pulse !== 1'(m_pulse) || day_count !== 16'(m_day) || load_err !== 1'(m_err)) begin
        failures++; $display("FAIL rnd_flags[%0d]: got pulse=%0b day=%0d err=%0b expected %0d/%0d/%0d", n, day_pulse, day_count, load_err, m_pulse, m_day, m_err);
      end
      checks++;
      if (load_ready !== (m_mode != 2)) begin
        failures++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", n, load_ready, m_mode != 2);
      end
    end
    load_valid = 1'b0; adj_field = 2'd0; adj_up = 1'b0; adj_down = 1'b0; tick_en = 1'b0;
    cycle();
  endtask

  task automatic test_async_reset();
    run = 1'b1; load_valid = 1'b1;
    load_hour = 5'd10; load_min = 6'd20; load_sec = 6'd30;
    cycle();
    load_valid = 1'b0; tick_en = 1'b1;
    checks++;
    if (hour !== 5'd10 || minute !== 6'd20 || second !== 6'd30) begin
      failures++; $display("FAIL pre_reset: got %0d:%0d:%0d expected 10:20:30", hour, minute, second);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd58 || day_count !== 16'd0 || day_pulse !== 1'b0) begin
      failures++; $display("FAIL async_reset: got %0d:%0d:%0d day=%0d pulse=%0b expected 23:59:58 day=0 pulse=0", hour, minute, second, day_count, day_pulse);
    end
    model_reset();
    #2 rst_n = 1'b1;
    cycle();
    checks++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd59) begin
      failures++; $display("FAIL post_reset_tick: got %0d:%0d:%0d expected 23:59:59", hour, minute, second);
    end
    tick_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_load_hold();
    test_load_err();
    test_adjust();
    test_12h();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
